// File: rtl/debounced_bcd_counter_pkg.sv
// ---------------------------------------------------------------------------
// debounced_bcd_counter_pkg
// Shared definitions for the debounced BCD up/down counter:
//   - bcd_digit_t : one packed BCD digit
//   - SEG_*       : 7-segment patterns (gfedcba, active-high) for 0-9 and blank
//   - MODE_*      : limit behaviour selectors for the SATURATE parameter
//   - step_t      : direction of a count update in a given cycle
//   - seg_decode  : BCD digit to segment pattern (codes 10-15 blank)
//   - to_bcd16    : elaboration-time conversion of a binary constant to BCD
// ---------------------------------------------------------------------------
package debounced_bcd_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_t;

    function automatic logic [6:0] seg_decode(input bcd_digit_t digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // Used only on parameters, so it never becomes hardware. Repeated
    // subtraction of powers of ten builds up to four BCD digits.
    function automatic logic [15:0] to_bcd16(input int unsigned value);
        int unsigned remain;
        int unsigned place;
        logic [15:0] result;
        remain = value;
        result = '0;
        for (int pos = 3; pos >= 0; pos--) begin
            place = 1;
            for (int j = 0; j < pos; j++) begin
                place = place * 10;
            end
            for (int k = 0; k < 9; k++) begin
                if (remain >= place) begin
                    remain = remain - place;
                    result[pos*4 +: 4] = result[pos*4 +: 4] + 4'd1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/debounced_bcd_counter_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Two-flop synchroniser followed by a DEB_W-bit stability counter. Emits a
// single-cycle step pulse once the button has been stably high long enough
// for the counter to reach all-ones.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-high reset
//   btn    - raw button, asynchronous to clock
//   step   - one-cycle registered pulse per qualified press
// ---------------------------------------------------------------------------
module button_debouncer
    import debounced_bcd_counter_pkg::*;
#(
    parameter int DEB_W = 18
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic step
);

    localparam logic [DEB_W-1:0] FULL      = {DEB_W{1'b1}};
    localparam logic [DEB_W-1:0] NEAR_FULL = {{(DEB_W-1){1'b1}}, 1'b0};
    localparam logic [DEB_W-1:0] ONE       = {{(DEB_W-1){1'b0}}, 1'b1};

    logic             sync_a;
    logic             sync_b;
    logic [DEB_W-1:0] count;

    // The pulse is raised on the same edge that moves the counter from
    // NEAR_FULL to FULL; once saturated the counter cannot make that move
    // again until the button drops and the count restarts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            count  <= '0;
            step   <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            if (!sync_b) begin
                count <= '0;
            end else if (count != FULL) begin
                count <= count + ONE;
            end
            step <= sync_b && (count == NEAR_FULL);
        end
    end

endmodule

// File: rtl/debounced_bcd_counter.sv
// ---------------------------------------------------------------------------
// debounced_bcd_counter
// BCD up/down counter driven by two debounced push buttons, with 7-segment
// decode of every digit and limit flags.
// Parameters:
//   DIGITS   - number of BCD digits (1..4)
//   DEB_W    - debounce counter width (2..24)
//   MAX_VAL  - upper count limit (1..10^DIGITS-1)
//   SATURATE - 0: wrap at limits, 1: hold at limits
// Ports:
//   clock, reset       - system clock / asynchronous active-high reset
//   btn_up, btn_down   - raw buttons, asynchronous to clock
//   clear              - synchronous clear of the count
//   bcd    [4*DIGITS]  - registered count, units in [3:0]
//   seg    [7*DIGITS]  - segments gfedcba, units in [6:0]
//   at_max, at_min     - count equals MAX_VAL / zero
// Build option: define BCD_COUNTER_BLANK_EN to blank leading-zero digits
// (the units digit is always shown).
// ---------------------------------------------------------------------------
module debounced_bcd_counter
    import debounced_bcd_counter_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int DEB_W    = 18,
    parameter int MAX_VAL  = 99,
    parameter int SATURATE = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  at_max,
    output logic                  at_min
);

    localparam logic [15:0]         MAX_BCD16 = to_bcd16(MAX_VAL);
    localparam logic [4*DIGITS-1:0] MAX_BCD   = MAX_BCD16[4*DIGITS-1:0];
    localparam bit                  HOLD_AT_LIMIT = (SATURATE == MODE_SATURATE);

    logic                step_up;
    logic                step_down;
    step_t               step_dir;
    logic [4*DIGITS-1:0] bcd_inc;
    logic [4*DIGITS-1:0] bcd_dec;
    logic [4*DIGITS-1:0] bcd_next;
    logic                carry;
    logic                borrow;
    bcd_digit_t          inc_digit;
    bcd_digit_t          dec_digit;
`ifdef BCD_COUNTER_BLANK_EN
    logic                leading;
`endif

    button_debouncer #(.DEB_W(DEB_W)) up_debouncer (
        .clock (clock),
        .reset (reset),
        .btn   (btn_up),
        .step  (step_up)
    );

    button_debouncer #(.DEB_W(DEB_W)) down_debouncer (
        .clock (clock),
        .reset (reset),
        .btn   (btn_down),
        .step  (step_down)
    );

    // Coincident pulses cancel out, so only a lone pulse moves the count.
    always_comb begin
        step_dir = STEP_HOLD;
        if (step_up && !step_down) begin
            step_dir = STEP_UP;
        end else if (step_down && !step_up) begin
            step_dir = STEP_DOWN;
        end
    end

    // Increment: a carry enters the units digit and ripples through nines.
    always_comb begin
        bcd_inc   = bcd;
        carry     = 1'b1;
        inc_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            inc_digit = bcd[4*i +: 4];
            if (carry) begin
                if (inc_digit == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = inc_digit + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Decrement: a borrow enters the units digit and ripples through zeros.
    always_comb begin
        bcd_dec   = bcd;
        borrow    = 1'b1;
        dec_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dec_digit = bcd[4*i +: 4];
            if (borrow) begin
                if (dec_digit == 4'd0) begin
                    bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*i +: 4] = dec_digit - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Limits are checked before the ripple result is used, so a MAX_VAL
    // below the all-nines value still wraps or holds at the right point.
    always_comb begin
        bcd_next = bcd;
        case (step_dir)
            STEP_UP: begin
                if (at_max) begin
                    bcd_next = HOLD_AT_LIMIT ? bcd : '0;
                end else begin
                    bcd_next = bcd_inc;
                end
            end
            STEP_DOWN: begin
                if (at_min) begin
                    bcd_next = HOLD_AT_LIMIT ? bcd : MAX_BCD;
                end else begin
                    bcd_next = bcd_dec;
                end
            end
            default: bcd_next = bcd;
        endcase
    end

    // clear wins over any step in the same cycle; the debouncers keep
    // their own state so a held button does not re-trigger.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcd <= '0;
        end else if (clear) begin
            bcd <= '0;
        end else begin
            bcd <= bcd_next;
        end
    end

    assign at_max = (bcd == MAX_BCD);
    assign at_min = (bcd == '0);

    // Segment decode. With blanking, a digit is dark while it and every
    // more-significant digit are zero, except the units digit.
    always_comb begin
        seg = '0;
`ifdef BCD_COUNTER_BLANK_EN
        leading = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            leading = leading && (bcd[4*i +: 4] == 4'd0);
            if (leading && (i != 0)) begin
                seg[7*i +: 7] = SEG_BLANK;
            end else begin
                seg[7*i +: 7] = seg_decode(bcd[4*i +: 4]);
            end
        end
`else
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = seg_decode(bcd[4*i +: 4]);
        end
`endif
    end

endmodule

// File: tb/tb_debounced_bcd_counter.sv
// ---------------------------------------------------------------------------
// tb_debounced_bcd_counter
// Self-checking bench for debounced_bcd_counter with DEB_W=4, DIGITS=2,
// MAX_VAL=99. Two instances share the inputs: one wraps at the limits, one
// saturates. Honours BCD_COUNTER_BLANK_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_debounced_bcd_counter;

    localparam int DEB_W   = 4;
    localparam int DIGITS  = 2;
    localparam int MAX_VAL = 99;

`ifdef BCD_COUNTER_BLANK_EN
    localparam logic [6:0] TENS_ZERO_SEG = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO_SEG = 7'h3F;
`endif

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic clear    = 1'b0;

    logic [4*DIGITS-1:0] bcd_w, bcd_s;
    logic [7*DIGITS-1:0] seg_w, seg_s;
    logic                at_max_w, at_min_w, at_max_s, at_min_s;

    always #5 clock = ~clock;

    debounced_bcd_counter #(
        .DIGITS(DIGITS), .DEB_W(DEB_W), .MAX_VAL(MAX_VAL), .SATURATE(0)
    ) dut_wrap (
        .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .clear(clear), .bcd(bcd_w), .seg(seg_w), .at_max(at_max_w), .at_min(at_min_w)
    );

    debounced_bcd_counter #(
        .DIGITS(DIGITS), .DEB_W(DEB_W), .MAX_VAL(MAX_VAL), .SATURATE(1)
    ) dut_sat (
        .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .clear(clear), .bcd(bcd_s), .seg(seg_s), .at_max(at_max_s), .at_min(at_min_s)
    );

    typedef struct {
        int    w;
        int    s;
        string name;
    } exp_t;

    typedef struct {
        bit    up;
        bit    down;
        int    hold;
        int    exp_w;
        int    exp_s;
        string name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   pass_count  = 0;
    int   check_count = 0;
    int   model_w     = 0;
    int   model_s     = 0;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

    function automatic logic [6:0] pattern(input int d);
        logic [6:0] table_p [10];
        table_p = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return table_p[d];
    endfunction

    function automatic logic [13:0] exp_seg(input int v);
        logic [6:0] tens_p;
        tens_p = pattern(v / 10);
`ifdef BCD_COUNTER_BLANK_EN
        if (v / 10 == 0) tens_p = 7'h00;
`endif
        return {tens_p, pattern(v % 10)};
    endfunction

    function automatic int next_w(input int v, input bit up, input bit down);
        if (up && !down)   return (v == MAX_VAL) ? 0 : v + 1;
        if (down && !up)   return (v == 0) ? MAX_VAL : v - 1;
        return v;
    endfunction

    function automatic int next_s(input int v, input bit up, input bit down);
        if (up && !down)   return (v == MAX_VAL) ? v : v + 1;
        if (down && !up)   return (v == 0) ? v : v - 1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkState(input string name, input int w, input int s);
        check({name, ".bcd_wrap"}, 32'(bcd_w), 32'(to_bcd(w)));
        check({name, ".bcd_sat"}, 32'(bcd_s), 32'(to_bcd(s)));
        check({name, ".seg_wrap"}, 32'(seg_w), 32'(exp_seg(w)));
        check({name, ".at_max_wrap"}, 32'(at_max_w), 32'(w == MAX_VAL));
        check({name, ".at_min_wrap"}, 32'(at_min_w), 32'(w == 0));
        check({name, ".at_max_sat"}, 32'(at_max_s), 32'(s == MAX_VAL));
        check({name, ".at_min_sat"}, 32'(at_min_s), 32'(s == 0));
    endtask

    // Drives one press (or hold pattern) and queues its expected result.
    task automatic applyStimulus(input bit up, input bit down, input int hold,
                                 input int exp_w, input int exp_s, input string name);
        exp_t e;
        e.w = exp_w;
        e.s = exp_s;
        e.name = name;
        sb.push_back(e);
        btn_up   = up;
        btn_down = down;
        repeat (hold) @(negedge clock);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    // Pops the oldest expectation and compares it against the settled DUTs.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            checkState(e.name, e.w, e.s);
            model_w = e.w;
            model_s = e.s;
        end
    endtask

    task automatic press(input bit up, input bit down, input string name);
        applyStimulus(up, down, 20, next_w(model_w, up, down), next_s(model_s, up, down), name);
        checkOutput();
    endtask

    task automatic doClear(input string name);
        exp_t e;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        e.w = 0;
        e.s = 0;
        e.name = name;
        sb.push_back(e);
        checkOutput();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Starting from count 1 (wrap) / 1 (saturate).
        vecs[0]  = '{1'b1, 1'b0, 20,  2, 2, "up_to_2"};
        vecs[1]  = '{1'b0, 1'b1, 20,  1, 1, "down_to_1"};
        vecs[2]  = '{1'b1, 1'b0, 10,  1, 1, "short_press"};
        vecs[3]  = '{1'b1, 1'b1, 20,  1, 1, "coincident"};
        vecs[4]  = '{1'b0, 1'b1, 20,  0, 0, "down_to_0"};
        vecs[5]  = '{1'b0, 1'b1, 20, 99, 0, "down_at_0"};
        vecs[6]  = '{1'b1, 1'b0, 20,  0, 1, "up_from_99"};
        vecs[7]  = '{1'b1, 1'b0, 20,  1, 2, "up_again"};
        vecs[8]  = '{1'b0, 1'b1, 20,  0, 1, "down_again"};
        vecs[9]  = '{1'b0, 1'b1, 20, 99, 0, "wrap_again"};
        vecs[10] = '{1'b0, 1'b1, 20, 98, 0, "borrow_98"};

        // Reset state, including a press that starts while reset is held.
        repeat (3) @(negedge clock);
        checkState("reset", 0, 0);
        check("reset.seg_raw", 32'(seg_w), 32'({TENS_ZERO_SEG, 7'h3F}));
        btn_up = 1'b1;
        repeat (5) @(negedge clock);
        check("held_in_reset", 32'(bcd_w), 32'h00);

        // Scenario 1 with exact latency: step lands on the 18th edge.
        reset = 1'b0;
        repeat (17) @(negedge clock);
        check("latency_edge17", 32'(bcd_w), 32'h00);
        @(negedge clock);
        check("latency_edge18", 32'(bcd_w), 32'h01);
        repeat (2) @(negedge clock);
        btn_up = 1'b0;
        repeat (6) @(negedge clock);
        checkState("scenario1", 1, 1);
        check("scenario1.seg", 32'(seg_w), 32'({TENS_ZERO_SEG, 7'h06}));
        model_w = 1;
        model_s = 1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].up, vecs[i].down, vecs[i].hold,
                          vecs[i].exp_w, vecs[i].exp_s, vecs[i].name);
            checkOutput();
        end

        // Scenario 2: one low cycle in the middle of a press restarts it.
        begin
            exp_t e;
            e.w = model_w;
            e.s = model_s;
            e.name = "glitch";
            sb.push_back(e);
        end
        btn_up = 1'b1;
        repeat (10) @(negedge clock);
        btn_up = 1'b0;
        @(negedge clock);
        btn_up = 1'b1;
        repeat (10) @(negedge clock);
        btn_up = 1'b0;
        repeat (6) @(negedge clock);
        checkOutput();

        // Carry and borrow across the digit boundary.
        doClear("clear_idle");
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0, "climb_to_9");
        applyStimulus(1'b1, 1'b0, 20, 10, 10, "carry_10");
        checkOutput();
        applyStimulus(1'b0, 1'b1, 20, 9, 9, "borrow_09");
        checkOutput();

        // Scenario 3: both instances at 99, then up and down.
        for (int i = 0; i < 90; i++) press(1'b1, 1'b0, "climb_to_99");
        check("at_99.bcd_sat", 32'(bcd_s), 32'h99);
        applyStimulus(1'b1, 1'b0, 20, 0, 99, "up_at_max");
        checkOutput();
        applyStimulus(1'b0, 1'b1, 20, 99, 98, "down_after_max");
        checkOutput();

        // Scenario 5: clear on the same cycle the up pulse lands.
        doClear("clear_before_45");
        for (int i = 0; i < 45; i++) press(1'b1, 1'b0, "climb_to_45");
        check("at_45", 32'(bcd_w), 32'h45);
        btn_up = 1'b1;
        repeat (17) @(negedge clock);
        check("pre_pulse_45", 32'(bcd_w), 32'h45);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear_vs_step.bcd", 32'(bcd_w), 32'h00);
        check("clear_vs_step.at_min", 32'(at_min_w), 32'd1);
        check("clear_vs_step.bcd_sat", 32'(bcd_s), 32'h00);
        repeat (5) @(negedge clock);
        btn_up = 1'b0;
        repeat (6) @(negedge clock);
        check("no_repulse", 32'(bcd_w), 32'h00);
        model_w = 0;
        model_s = 0;
        press(1'b1, 1'b0, "after_clear_up");

        // Scenario 6: leading-zero behaviour at 07.
        doClear("clear_before_07");
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0, "climb_to_7");
        check("seg07.tens", 32'(seg_w[13:7]), 32'(TENS_ZERO_SEG));
        check("seg07.units", 32'(seg_w[6:0]), 32'h07);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/debounced_bcd_counter.md
DEBOUNCED_BCD_COUNTER -- requirements
Module: debounced_bcd_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of BCD digits and 7-segment outputs (1..4).
REQ-002 SHALL have parameter DEB_W, default 18, debounce counter width in bits (2..24).
REQ-003 SHALL have parameter MAX_VAL, default 99, upper count limit (1..10^DIGITS-1).
REQ-004 SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-005 SHALL have clock and reset as stated: reset reset, asynchronous, active-high; clock clock.
REQ-006 clock  input  1  system clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 btn_up  input  1  raw increment button, active-high, asynchronous to clock.
REQ-009 btn_down  input  1  raw decrement button, active-high, asynchronous to clock.
REQ-010 clear  input  1  synchronous clear of the count to 0.
REQ-011 bcd  output  4*DIGITS  registered count, BCD; digit 0 (units) in bits [3:0].
REQ-012 seg  output  7*DIGITS  segments gfedcba, active-high; digit 0 in bits [6:0].
REQ-013 at_max  output  1  high while count == MAX_VAL.
REQ-014 at_min  output  1  high while count == 0.

Function
REQ-015 Each button SHALL pass a 2-flop synchroniser and then a DEB_W-bit debounce counter.
- Counter clears when the synchronised button is low and increments, saturating at all-ones, while it is high.
REQ-016 Each debouncer SHALL emit a one-cycle step pulse on the cycle its counter goes from 2^DEB_W-2 to 2^DEB_W-1.
- Exactly one pulse per press; no pulse on release; a glitch shorter than 2^DEB_W-1 cycles produces none.
REQ-017 The count SHALL update in the cycle after the step pulse: 3 cycles of synchroniser/pulse latency plus 2^DEB_W-1 stable-high cycles from the raw edge.
REQ-018 Count arithmetic SHALL be per-digit BCD with carry/borrow ripple; no binary divide or modulo.
REQ-019 An up step at MAX_VAL SHALL give 0 when SATURATE=0 and hold MAX_VAL when SATURATE=1.
REQ-020 A down step at 0 SHALL give MAX_VAL when SATURATE=0 and hold 0 when SATURATE=1.
REQ-021 Coincident up and down step pulses SHALL leave the count unchanged.
REQ-022 clear SHALL override any step pulse in the same cycle and SHALL NOT reset the debouncers.
REQ-023 seg SHALL be combinational from bcd; digit codes 0-9 use standard patterns (0 = 7'h3F); codes 10-15 give 7'h00.
REQ-024 at_max and at_min SHALL be combinational from bcd.

Reset
REQ-025 While reset is high, bcd SHALL be 0, both debounce counters 0, synchronisers 0 and no step pulse.
REQ-026 After reset, seg SHALL show 7'h3F on every digit (subject to REQ-028), at_min = 1 and at_max = 0.
REQ-027 A press in progress at reset assertion SHALL be discarded; a still-held button after release of reset needs a full debounce interval to step.

Configuration
REQ-028 Macro BCD_COUNTER_BLANK_EN:
- Defined: each non-units digit whose value and all more-significant digits are 0 SHALL output seg 7'h00.
- Undefined: all digits always decoded; the units digit is never blanked.

Structure
REQ-029 A shared package SHALL hold the segment pattern constants (digits 0-9, blank), the BCD digit typedef and the wrap/saturate mode constants.
REQ-030 The synchroniser plus debounce counter plus pulse logic SHALL be one sub-module, button_debouncer (parameter DEB_W), instantiated twice.

Verification
(All scenarios use DEB_W=4 and default DIGITS/MAX_VAL.)
REQ-031 Scenario 1: reset, then btn_up high for 20 cycles -> bcd goes 00 to 01 once, seg = {7'h3F, 7'h06}.
REQ-032 Scenario 2: btn_up high 10 cycles, low 1, high 10 -> no step pulse, bcd unchanged.
REQ-033 Scenario 3: SATURATE=0, count 99, one up press -> 00; then one down press -> 99. SATURATE=1, same presses -> 99 then 98.
REQ-034 Scenario 4: btn_up and btn_down raised on the same cycle, held 20 cycles -> coincident pulses, bcd unchanged.
REQ-035 Scenario 5: count 45, clear asserted on the cycle of an up step pulse -> bcd = 00, at_min = 1.
REQ-036 Scenario 6: count 07 with BCD_COUNTER_BLANK_EN defined -> seg[13:7] = 7'h00; without it -> 7'h3F.
